// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bundle for instr_loader.
//   byte_data / byte_valid / byte_ready : program byte stream (valid/ready handshake)
//   imem_we / imem_addr / imem_wdata    : instruction-memory write port
// Modports:
//   slave  - the loader's view: sinks the byte stream, drives the write port
//   master - the environment's view: sources bytes, observes the write port
interface instr_loader_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader for the MIPS core's instruction memory.
// Receives a 16-bit big-endian word count followed by that many big-endian
// 32-bit words over a byte handshake, writes each word to the instruction
// memory, and keeps the core in reset until the whole program is in place.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - one-cycle pulse to begin a load (honoured in IDLE, DONE, ERR)
//   bus      - byte stream in, instruction-memory write port out
//   core_rst - core reset, high whenever the loader is not in DONE
//   done     - load finished successfully
//   error    - header word count was 0 or larger than DEPTH_WORDS
module instr_loader #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  instr_loader_if.slave  bus,
  output logic           core_rst,
  output logic           done,
  output logic           error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       count;
  logic [IDX_W-1:0]  index;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;

  logic              fire;
  logic [15:0]       count_full;
  logic              count_bad;
  logic [IDX_W-1:0]  index_inc;
  logic              last_word;

  assign fire       = bus.byte_valid && bus.byte_ready;
  // Full count as it will be once the low header byte is latched.
  assign count_full = {count[15:8], bus.byte_data};
  assign count_bad  = (count_full == 16'd0) || (count_full > 16'(DEPTH_WORDS));
  assign index_inc  = index + IDX_W'(1);
  assign last_word  = (16'(index_inc) == count);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and process ordering cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    bus.byte_ready = 1'b0;
    bus.imem_we    = 1'b0;
    core_rst       = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        bus.byte_ready = 1'b1;
        if (bus.byte_valid) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        bus.byte_ready = 1'b1;
        if (bus.byte_valid) state_nxt = count_bad ? ERR : DATA;
      end
      DATA: begin
        bus.byte_ready = 1'b1;
        if (bus.byte_valid && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        // byte_ready stays low here, so a source holding valid simply waits.
        bus.imem_we = 1'b1;
        state_nxt   = last_word ? DONE : DATA;
      end
      DONE: begin
        done     = 1'b1;
        core_rst = 1'b0;
        if (start) state_nxt = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nxt = LEN_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. imem_addr / imem_wdata are registered when the 4th byte of a
  // word arrives, so they are valid throughout WRITE and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      index          <= '0;
      byte_cnt       <= '0;
      shift          <= '0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      case (state)
        LEN_HI: begin
          if (fire) count[15:8] <= bus.byte_data;
        end
        LEN_LO: begin
          if (fire) begin
            count[7:0] <= bus.byte_data;
            index      <= '0;
            byte_cnt   <= '0;
          end
        end
        DATA: begin
          if (fire) begin
            shift    <= {shift[15:0], bus.byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.imem_wdata <= {shift, bus.byte_data};
              bus.imem_addr  <= 32'(index) << 2;
            end
          end
        end
        WRITE: begin
          index <= index_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader: reset values, two-word load timing,
// gapped stream, start filtering, illegal counts, full-depth load, error
// recovery and asynchronous reset mid-load.
module tb_instr_loader;

  logic clk;
  logic rst;
  logic start;
  logic core_rst;
  logic done;
  logic error;

  instr_loader_if bus ();

  instr_loader #(.DEPTH_WORDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [7:0]  stream [0:259];
  int          stream_len;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          xfer_cnt;
  int          stall_viol;
  int          lat;
  int          edges;
  logic        rst_1, done_1, error_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Observes the write port and the handshake between clock edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_we) begin
        wr_addr.push_back(bus.imem_addr);
        wr_data.push_back(bus.imem_wdata);
      end
      if (bus.byte_valid && bus.byte_ready) xfer_cnt++;
      if (bus.imem_we && bus.byte_ready) stall_viol++;
    end
  end

  task automatic set_header(input int n);
    stream[0]  = n[15:8];
    stream[1]  = n[7:0];
    stream_len = 2;
  endtask

  task automatic put_word(input logic [31:0] w);
    stream[stream_len]   = w[31:24];
    stream[stream_len+1] = w[23:16];
    stream[stream_len+2] = w[15:8];
    stream[stream_len+3] = w[7:0];
    stream_len += 4;
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, 8'hA5, ~b, 8'h3C};
  endfunction

  task automatic drive_byte(input int pos, input int gap_pct);
    if (pos < stream_len) begin
      bus.byte_data  = stream[pos];
      bus.byte_valid = int'($urandom_range(99, 0)) >= gap_pct;
    end else begin
      bus.byte_data  = 8'h00;
      bus.byte_valid = 1'b0;
    end
  endtask

  // Pulses start and plays the stream. edges counts rising edges, the first
  // being the one that samples start; lat is the edge count at which done or
  // error is first seen (-1 if never). abort_at > 0 returns early at that
  // edge's following falling edge.
  task automatic load(input int gap_pct, input int mid_start_at,
                      input int abort_at, input int max_cyc);
    int pos;
    bit take;
    pos   = 0;
    lat   = -1;
    edges = 0;
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
    xfer_cnt   = 0;
    stall_viol = 0;
    start      = 1'b1;
    drive_byte(pos, gap_pct);
    @(negedge clk);
    take = bus.byte_valid && bus.byte_ready;
    while (edges < max_cyc) begin
      @(posedge clk);
      edges++;
      #1;
      start = (edges == mid_start_at);
      if (take) pos++;
      drive_byte(pos, gap_pct);
      @(negedge clk);
      if (edges == 1) begin
        rst_1   = core_rst;
        done_1  = done;
        error_1 = error;
      end
      if (done || error) begin
        lat = edges;
        break;
      end
      if (edges == abort_at) break;
      take = bus.byte_valid && bus.byte_ready;
    end
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    if (abort_at == 0) check("load_finished", 32'(lat >= 0), 32'd1);
  endtask

  task automatic set_two_word;
    set_header(2);
    put_word(32'h2008_0005);
    put_word(32'h8C09_0004);
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwr"}, wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
      check({tag, "_d0"}, wr_data[0], 32'h2008_0005);
      check({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
      check({tag, "_d1"}, wr_data[1], 32'h8C09_0004);
    end
    check({tag, "_xfer"},  xfer_cnt, 32'd10);
    check({tag, "_stall"}, stall_viol, 32'd0);
    check({tag, "_done"},  done, 1'b1);
    check({tag, "_crst"},  core_rst, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed=running expected=finished)");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    rst            = 1'b1;
    start          = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset values, before any clock edge.
    #3;
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_ready",    bus.byte_ready, 1'b0);
    check("rst_we",       bus.imem_we, 1'b0);
    check("rst_done",     done, 1'b0);
    check("rst_error",    error, 1'b0);
    check("rst_addr",     bus.imem_addr, 32'h0);
    check("rst_wdata",    bus.imem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Two-word load, valid always high: DONE after 1 + 2 + 5*2 edges.
    set_two_word();
    load(0, 0, 0, 100);
    check("two_lat", lat, 32'd13);
    check_two_word("two");

    // Start in DONE: core_rst rises at once, second program loads from 0.
    set_header(3);
    put_word(32'h3C01_1001);
    put_word(32'h3421_0000);
    put_word(32'hAC22_0008);
    load(0, 0, 0, 100);
    check("redo_crst_after_start", rst_1, 1'b1);
    check("redo_done_after_start", done_1, 1'b0);
    check("redo_lat", lat, 32'd18);
    check("redo_nwr", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      check("redo_a0", wr_addr[0], 32'h0);
      check("redo_d0", wr_data[0], 32'h3C01_1001);
      check("redo_a2", wr_addr[2], 32'h8);
      check("redo_d2", wr_data[2], 32'hAC22_0008);
    end

    // Gapped stream: identical writes, nothing consumed during WRITE.
    set_two_word();
    load(40, 0, 0, 300);
    check_two_word("gap");

    // start pulsed during DATA is ignored.
    set_two_word();
    load(0, 4, 0, 100);
    check("mid_lat", lat, 32'd13);
    check_two_word("mid");

    // Count 0 -> ERR after the header, no writes.
    set_header(0);
    load(0, 0, 0, 100);
    check("zero_lat",   lat, 32'd3);
    check("zero_error", error, 1'b1);
    check("zero_done",  done, 1'b0);
    check("zero_crst",  core_rst, 1'b1);
    check("zero_nwr",   wr_addr.size(), 32'd0);

    // Error recovery: one-word program.
    set_header(1);
    put_word(32'hDEAD_BEEF);
    load(0, 0, 0, 100);
    check("rec_err_after_start", error_1, 1'b0);
    check("rec_lat",   lat, 32'd8);
    check("rec_nwr",   wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("rec_a0", wr_addr[0], 32'h0);
      check("rec_d0", wr_data[0], 32'hDEAD_BEEF);
    end
    check("rec_done",  done, 1'b1);
    check("rec_error", error, 1'b0);

    // DEPTH_WORDS + 1 -> ERR.
    set_header(65);
    load(0, 0, 0, 100);
    check("over_lat",   lat, 32'd3);
    check("over_error", error, 1'b1);
    check("over_nwr",   wr_addr.size(), 32'd0);

    // Exactly DEPTH_WORDS: 64 writes, last at 0xFC.
    set_header(64);
    for (int i = 0; i < 64; i++) put_word(pat(i));
    load(0, 0, 0, 1000);
    check("full_lat", lat, 32'd323);
    check("full_nwr", wr_addr.size(), 32'd64);
    mism = 0;
    for (int i = 0; i < wr_addr.size() && i < 64; i++)
      if (wr_addr[i] !== 32'(i) * 32'd4 || wr_data[i] !== pat(i)) mism++;
    check("full_mismatches", mism, 32'd0);
    if (wr_addr.size() == 64) check("full_last_addr", wr_addr[63], 32'h0000_00FC);
    check("full_done", done, 1'b1);

    // Asynchronous reset in the middle of the second word's DATA phase.
    set_two_word();
    load(0, 0, 9, 100);
    check("abort_pre_ready", bus.byte_ready, 1'b1);
    check("abort_pre_wdata", bus.imem_wdata, 32'h2008_0005);
    #2;
    rst = 1'b1;
    #1;
    check("abort_crst",  core_rst, 1'b1);
    check("abort_ready", bus.byte_ready, 1'b0);
    check("abort_we",    bus.imem_we, 1'b0);
    check("abort_done",  done, 1'b0);
    check("abort_wdata", bus.imem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. It receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to the instruction memory through a dedicated write port. It holds the core in reset until the load completes, then releases it so execution starts at PC 0.

## Interface
Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; legal word counts are 1..DEPTH_WORDS.

Ports:
- clk  in  1  global clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset. Clears all state immediately.
- start  in  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- byte_data  in  8  incoming program byte.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle. A transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the word being written: word index × 4. Bits [1:0] are always 0.
- imem_wdata  out  32  assembled instruction word.
- core_rst  out  1  reset to the processor core. High whenever the loader is not in DONE.
- done  out  1  load completed successfully.
- error  out  1  the header word count was illegal.

## Operation
Stream format: a 2-byte word count N (MSB first), followed by N×4 program bytes. Each word is sent MSB first, so the first byte of a word lands in [31:24].

States and transitions:
- IDLE: byte_ready=0, core_rst=1. On start, go to LEN_HI.
- LEN_HI: byte_ready=1. On transfer, latch count[15:8] and go to LEN_LO.
- LEN_LO: byte_ready=1. On transfer, latch count[7:0], then:
  - If the full count is 0 or greater than DEPTH_WORDS, go to ERR.
  - Otherwise clear the word index and byte counter and go to DATA.
- DATA: byte_ready=1. On each transfer, shift the byte into the word register (MSB first). After the 4th byte, go to WRITE.
- WRITE: byte_ready=0; imem_we=1, imem_addr=index×4, imem_wdata=assembled word. Increment the index. If the new index equals the count, go to DONE; otherwise go to DATA.
- DONE: done=1, core_rst=0. On start, go to LEN_HI, reasserting core_rst and clearing done.
- ERR: error=1, core_rst=1. On start, go to LEN_HI and clear error.

Other rules:
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- byte_valid while byte_ready=0 is not consumed; the source must hold the byte.
- The index counter is wide enough for DEPTH_WORDS.
- The count register is 16 bits; the comparison against DEPTH_WORDS is unsigned.
- imem_addr and imem_wdata hold their last values outside WRITE and are don't-care to consumers when imem_we=0.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE, so core_rst=1.
  - byte_ready=0, imem_we=0, done=0, error=0.
  - imem_addr=0, imem_wdata=0, all counters 0.
- start is sampled at edge t; byte_ready is high from cycle t+1.
- The 4th byte of a word is accepted at edge t; imem_we is high during cycle t+1 only; byte_ready returns high in cycle t+2.
- Throughput: at most one word per 5 cycles.
- Load latency, with byte_valid held high: 1 (start) + 2 (header) + 5N cycles to DONE.
- core_rst falls in the cycle DONE is entered, which is the cycle after the last imem_we.
- Reset asserted mid-load aborts immediately. Partially written memory is left as is, and core_rst stays high.
- A back-to-back stream with byte_valid held high must not drop or duplicate bytes across WRITE stalls.

## Test plan
- **Reset:** assert rst mid-DATA → outputs drop to reset values in the same cycle without waiting for clk; core_rst=1, byte_ready=0.
- **Two-word load:** start; bytes 00 02 20 08 00 05 8C 09 00 04 with valid always high → imem_we pulses twice: addr 0 / 0x20080005, then addr 4 / 0x8C090004. done=1 and core_rst=0 exactly 13 cycles after start.
- **Gapped stream:** same stream, with byte_valid deasserted on random cycles → identical writes. Also check that no byte is consumed during the WRITE cycles.
- **Illegal counts:** count 0x0000 → ERR, error=1, no imem_we. Count DEPTH_WORDS+1 (0x0041) → ERR. Count 0x0040 → 64 writes, with the last at addr 0xFC.
- **Start filtering:** start pulsed during DATA → ignored, load completes normally. start in DONE → core_rst rises the next cycle, done clears, and a second program loads from addr 0.
- **Error recovery:** start in ERR followed by a valid 1-word stream → error clears, one write, done=1.
